// File: rtl/wb_arbiter2_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// State encoding and grant indices.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Stall counter for an owned bus cycle.
// Pulses expire_o once TIMEOUT stalled strobes have elapsed.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam bit ON = (TIMEOUT > 0);
  localparam int CW = ON ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Compare with >= so a held count never slips past the limit.
  assign expire_o = ON && en_i && (cnt_q >= LIMIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || expire_o) begin
      cnt_q <= '0;
    end else if (ON && en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter, round-robin per CYC,
// with a stalled-cycle timeout that forces ERR to the owner.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  output logic [1:0]          gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       own0, own1, owned;
  logic       tmo_en, tmo_clr, tmo_exp;
  logic       err_any, ack_any;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= GNT_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Handover always passes through IDLE, leaving one dead cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q == GNT_M1)) begin
          state_d = OWN0;
          last_d  = GNT_M0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
          last_d  = GNT_M1;
        end
      end
      OWN0: if (!m0_cyc_i) state_d = IDLE;
      OWN1: if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign own0  = (state_q == OWN0);
  assign own1  = (state_q == OWN1);
  assign owned = own0 | own1;
  assign gnt_o = {own1, own0};

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    unique case (1'b1)
      own0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
      end
      own1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
      end
      default: begin
      end
    endcase
  end

  assign tmo_en  = owned & s_stb_o & ~s_ack_i & ~s_err_i;
  assign tmo_clr = ~owned | s_ack_i | s_err_i;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_exp)
  );

  // Error beats ack when both arrive together.
  assign err_any = s_err_i | tmo_exp;
  assign ack_any = s_ack_i & ~err_any;

  assign m0_dat_o = owned ? s_dat_i : '0;
  assign m1_dat_o = owned ? s_dat_i : '0;
  assign m0_ack_o = own0 & ack_any;
  assign m0_err_o = own0 & err_any;
  assign m1_ack_o = own1 & ack_any;
  assign m1_err_o = own1 & err_any;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: vector table, corner sequences,
// and random traffic against an owner/stall reference model.
module tb_wb_arbiter2;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  gnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter2 #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m0_cyc_i  (m0_cyc_i),
    .m0_stb_i  (m0_stb_i),
    .m0_we_i   (m0_we_i),
    .m0_addr_i (m0_addr_i),
    .m0_dat_i  (m0_dat_i),
    .m0_sel_i  (m0_sel_i),
    .m0_dat_o  (m0_dat_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_cyc_i  (m1_cyc_i),
    .m1_stb_i  (m1_stb_i),
    .m1_we_i   (m1_we_i),
    .m1_addr_i (m1_addr_i),
    .m1_dat_i  (m1_dat_i),
    .m1_sel_i  (m1_sel_i),
    .m1_dat_o  (m1_dat_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .gnt_o     (gnt_o)
  );

  typedef struct packed {
    logic [1:0]  gnt;
    logic        scyc, sstb, swe;
    logic [31:0] saddr, sdat;
    logic [3:0]  ssel;
    logic [31:0] m0dat;
    logic        m0ack, m0err;
    logic [31:0] m1dat;
    logic        m1ack, m1err;
  } out_t;

  out_t act;
  assign act = {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o,
                s_dat_o, s_sel_o, m0_dat_o, m0_ack_o, m0_err_o,
                m1_dat_o, m1_ack_o, m1_err_o};

  logic [71:0] act_s;
  assign act_s = {gnt_o, s_cyc_o, s_we_o, s_addr_o, m0_ack_o,
                  m0_err_o, m1_ack_o, m1_err_o, m0_dat_o};

  task automatic check(input string nm, input logic [159:0] a,
                       input logic [159:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic zero_inputs();
    {m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i} = '0;
    {m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i} = '0;
    {s_dat_i, s_ack_i, s_err_i} = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    zero_inputs();
    rst_i = 1'b0;
    #1 check("reset_outputs", 160'(act), 160'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
  endtask

  task automatic fixed_masters();
    m0_we_i = 1'b0; m0_addr_i = 32'h0;
    m0_dat_i = 32'h0; m0_sel_i = 4'hF;
    m1_we_i = 1'b1; m1_addr_i = 32'h100;
    m1_dat_i = 32'hDEADBEEF; m1_sel_i = 4'hF;
    s_dat_i = 32'h13;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst;
    logic [5:0] in;
    logic [71:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic [5:0] in,
                              logic [1:0] g, logic sc, logic sw,
                              logic [31:0] ad, logic [3:0] ae,
                              logic [31:0] d);
    vec_t v;
    v.rst = r;
    v.in  = in;
    v.exp = {g, sc, sw, ad, ae, d};
    return v;
  endfunction

  localparam logic [31:0] A1 = 32'h100;
  localparam logic [31:0] D = 32'h13;

  // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err}
  // ae = {m0_ack, m0_err, m1_ack, m1_err}
  vec_t tbl[27];

  task automatic run_table();
    tbl[0]  = mk(1, 6'b111100, 2'b00, 0, 0, 0,  4'b0000, 0);
    tbl[1]  = mk(0, 6'b111100, 2'b01, 1, 0, 0,  4'b0000, D);
    tbl[2]  = mk(0, 6'b111110, 2'b01, 1, 0, 0,  4'b1000, D);
    tbl[3]  = mk(0, 6'b001100, 2'b01, 0, 0, 0,  4'b0000, D);
    tbl[4]  = mk(0, 6'b001100, 2'b00, 0, 0, 0,  4'b0000, 0);
    tbl[5]  = mk(0, 6'b001100, 2'b10, 1, 1, A1, 4'b0000, D);
    tbl[6]  = mk(0, 6'b001110, 2'b10, 1, 1, A1, 4'b0010, D);
    tbl[7]  = mk(0, 6'b000000, 2'b10, 0, 1, A1, 4'b0000, D);
    tbl[8]  = mk(0, 6'b111100, 2'b00, 0, 0, 0,  4'b0000, 0);
    tbl[9]  = mk(0, 6'b111100, 2'b01, 1, 0, 0,  4'b0000, D);
    tbl[10] = mk(0, 6'b001110, 2'b01, 0, 0, 0,  4'b1000, D);
    tbl[11] = mk(0, 6'b001100, 2'b00, 0, 0, 0,  4'b0000, 0);
    tbl[12] = mk(0, 6'b111100, 2'b10, 1, 1, A1, 4'b0000, D);
    tbl[13] = mk(0, 6'b111110, 2'b10, 1, 1, A1, 4'b0010, D);
    tbl[14] = mk(0, 6'b111111, 2'b10, 1, 1, A1, 4'b0001, D);
    tbl[15] = mk(0, 6'b110000, 2'b10, 0, 1, A1, 4'b0000, D);
    tbl[16] = mk(0, 6'b110000, 2'b00, 0, 0, 0,  4'b0000, 0);
    tbl[17] = mk(0, 6'b111100, 2'b01, 1, 0, 0,  4'b0000, D);
    tbl[18] = mk(0, 6'b111110, 2'b01, 1, 0, 0,  4'b1000, D);
    tbl[19] = mk(0, 6'b101100, 2'b01, 1, 0, 0,  4'b0000, D);
    tbl[20] = mk(0, 6'b111110, 2'b01, 1, 0, 0,  4'b1000, D);
    tbl[21] = mk(0, 6'b111110, 2'b01, 1, 0, 0,  4'b1000, D);
    tbl[22] = mk(0, 6'b001100, 2'b01, 0, 0, 0,  4'b0000, D);
    tbl[23] = mk(0, 6'b001111, 2'b00, 0, 0, 0,  4'b0000, 0);
    tbl[24] = mk(0, 6'b001100, 2'b10, 1, 1, A1, 4'b0000, D);
    tbl[25] = mk(0, 6'b000000, 2'b10, 0, 1, A1, 4'b0000, D);
    tbl[26] = mk(0, 6'b000010, 2'b00, 0, 0, 0,  4'b0000, 0);
    for (int i = 0; i < 27; i++) begin
      if (tbl[i].rst) do_reset();
      @(posedge clk_i); #1;
      fixed_masters();
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i,
       s_ack_i, s_err_i} = tbl[i].in;
      #3 check($sformatf("vec[%0d]", i),
               160'(act_s), 160'(tbl[i].exp));
    end
  endtask

  // ---------------- corner sequences ----------------
  task automatic run_timeout();
    do_reset();
    @(posedge clk_i); #1;
    fixed_masters();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk_i); #4;
      check($sformatf("tmo_err_beat%0d", n),
            160'({m0_err_o, m1_err_o, m0_ack_o, gnt_o}),
            160'({(n == 5 || n == 10), 1'b0, 1'b0, 2'b01}));
    end
    @(posedge clk_i); #1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(posedge clk_i); #4;
    check("tmo_release", 160'({gnt_o, s_cyc_o}), 160'(0));
  endtask

  task automatic run_async_reset();
    do_reset();
    @(posedge clk_i); #1;
    fixed_masters();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    @(posedge clk_i); #1;
    s_ack_i = 1'b1; s_err_i = 1'b1;
    #2 check("both_resp_m1",
             160'({gnt_o, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}),
             160'({2'b10, 4'b1000}));
    rst_i = 1'b0;
    #1 check("async_reset", 160'(act), 160'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    zero_inputs();
  endtask

  // ---------------- random vs model ----------------
  int own, last, stall;

  function automatic bit stall_hit(bit stb);
    return stb && !s_ack_i && !s_err_i && stall >= TMO;
  endfunction

  task automatic model_out(output out_t e);
    bit stb, er;
    e = '0;
    if (own == 0) begin
      e.gnt = 2'b01; e.scyc = m0_cyc_i; e.sstb = m0_stb_i;
      e.swe = m0_we_i; e.saddr = m0_addr_i;
      e.sdat = m0_dat_i; e.ssel = m0_sel_i;
    end else if (own == 1) begin
      e.gnt = 2'b10; e.scyc = m1_cyc_i; e.sstb = m1_stb_i;
      e.swe = m1_we_i; e.saddr = m1_addr_i;
      e.sdat = m1_dat_i; e.ssel = m1_sel_i;
    end
    if (own >= 0) begin
      stb = e.sstb;
      er = s_err_i || stall_hit(stb);
      e.m0dat = s_dat_i;
      e.m1dat = s_dat_i;
      if (own == 0) begin
        e.m0err = er; e.m0ack = s_ack_i && !er;
      end else begin
        e.m1err = er; e.m1ack = s_ack_i && !er;
      end
    end
  endtask

  task automatic model_step();
    bit stb, cyc;
    if (own < 0) begin
      stall = 0;
      if (m0_cyc_i && (!m1_cyc_i || last == 1)) begin
        own = 0; last = 0;
      end else if (m1_cyc_i) begin
        own = 1; last = 1;
      end
    end else begin
      stb = (own == 0) ? m0_stb_i : m1_stb_i;
      cyc = (own == 0) ? m0_cyc_i : m1_cyc_i;
      if (s_ack_i || s_err_i || stall_hit(stb)) stall = 0;
      else if (stb) stall++;
      if (!cyc) begin
        own = -1; stall = 0;
      end
    end
  endtask

  task automatic run_random();
    out_t e;
    do_reset();
    own = -1; last = 1; stall = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_i); #1;
      if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_dat_i = $urandom; m1_dat_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      s_dat_i = $urandom;
      // Alternate phases with and without acks to hit timeouts.
      s_ack_i = ((c / 400) % 2 == 0) && ($urandom_range(0, 3) == 0);
      s_err_i = ($urandom_range(0, 31) == 0);
      #3;
      model_out(e);
      check($sformatf("rand[%0d]", c), 160'(act), 160'(e));
      model_step();
    end
  endtask

  initial begin
    zero_inputs();
    run_table();
    run_timeout();
    run_async_reset();
    run_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Shares the single memory bus between the instruction-fetch port (master 0) and the data-memory port (master 1).
- Grants ownership per bus cycle (CYC-level lock) with round-robin priority.
- Routes slave responses back to the owner only, and terminates hung cycles with a timeout error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (SEL width = DATA_W/8).
- TIMEOUT, 255, cycles without ACK/ERR before the arbiter forces ERR to the owner; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (fetch) cycle/strobe/write.
- m0_addr_i  in  ADDR_W  master 0 address.
- m0_dat_i  in  DATA_W  master 0 write data.
- m0_sel_i  in  DATA_W/8  master 0 byte select.
- m0_dat_o  out  DATA_W  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  termination to master 0.
- m1_*  same set as m0_*, for master 1 (data memory).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write.
- s_addr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_sel_o  out  DATA_W/8  slave byte select.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i, s_err_i  in  1 each  slave termination.
- gnt_o  out  2  one-hot current owner; 00 = idle (debug/perf).

Behaviour:
- Reset (rst_i low, async):
  - state = IDLE, last_gnt = master 1 (so master 0 wins the first tie), timeout counter = 0.
  - All outputs 0, s_* and m*_* included.
- States: IDLE, OWN0, OWN1.
- IDLE transitions:
  - m0_cyc_i only -> OWN0; m1_cyc_i only -> OWN1.
  - Both asserted -> grant the master that is not last_gnt; last_gnt updates on grant.
  - Grant is registered: one cycle of arbitration latency from CYC to s_cyc_o.
- OWNx:
  - s_cyc_o/stb_o/we_o/addr_o/dat_o/sel_o are combinationally muxed from master x.
  - s_dat_i is forwarded to both m*_dat_o. Only the owner sees ack/err; the non-owner gets ack=err=0.
- Lock and release:
  - The owner keeps the bus while its CYC stays high, including across multiple STB beats.
  - On owner CYC falling, return to IDLE next cycle. No same-cycle handover: a pending request is granted from IDLE, giving a minimum 1 idle cycle between owners.
- Timeout:
  - Counter increments each cycle in OWNx with s_stb_o=1 and no s_ack_i/s_err_i. It clears on ack/err, on a new grant, and in IDLE.
  - When it reaches TIMEOUT, assert mx_err_o for one cycle and clear the counter.
  - The master is expected to drop CYC; ownership is still released only on CYC low.
- Simultaneous s_ack_i and s_err_i: err wins, and the owner sees err=1, ack=0.
- Unowned responses: s_ack_i/s_err_i while IDLE are ignored and never reach either master.
- Owner drops CYC in the same cycle as ack: the transaction is complete, and the arbiter goes to IDLE.
- Reset mid-cycle: all outputs drop immediately (async). The slave observes CYC falling and must abandon the transfer.
- Counter width: clog2(TIMEOUT+1), saturating compare, no wrap.

Decomposition:
- Shared package: arbiter state encoding (IDLE/OWN0/OWN1, 2 bits) and grant index constants (GNT_M0, GNT_M1).
- Sub-module: wb_timeout_cnt, holding the counter, clear/enable, and a one-cycle expire pulse.
- Arbitration FSM and muxing stay in the top level.

Test Plan:
- Reset then m0 read addr 0x0000_0000 alone:
  - s_cyc_o rises 1 cycle after m0_cyc_i, gnt_o=01.
  - Slave acks with 0x0000_0013 -> m0_dat_o=0x13, m0_ack_o=1, m1_ack_o=0.
- Both CYC rise together from reset:
  - Master 0 granted first.
  - After m0 releases, 1 idle cycle, then m1 granted (gnt_o=10).
  - Next tie -> master 0.
- m1 write addr 0x100, dat 0xDEADBEEF, sel 0xF while m0 requests:
  - m0 is held off until m1 drops CYC.
  - s_we_o=1, s_sel_o=0xF throughout, and m0 never sees ack.
- Multi-beat lock: m0 holds CYC across 3 STB/ACK beats while m1 requests -> no grant change until m0 CYC is low.
- TIMEOUT=4, slave never acks:
  - m0_err_o pulses in exactly the 5th STB cycle.
  - The counter clears, and the bus is released after m0 drops CYC.
- s_ack_i and s_err_i together during OWN1, then rst_i low mid-transfer:
  - m1_err_o=1, m1_ack_o=0.
  - On reset, all outputs go to 0 without waiting for a clock edge.
